// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and the
// even-parity helper used by both the sender and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam int unsigned DATA_BITS  = 7;
    localparam int unsigned FRAME_BITS = 10;

    // Parity bit that makes the character plus parity contain an even number of ones.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Receive-side signal bundle: serial line in, parallel character and status out.
interface uart_rx_sampler_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS:0]   data_out;
    logic                 out_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    // Receiver side: consumes the line, produces the character and status.
    modport master (
        input  rx,
        output data_out,
        output out_valid,
        output parity_err,
        output frame_err,
        output busy
    );

    // Line driver / character consumer side.
    modport slave (
        output rx,
        input  data_out,
        input  out_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; resets to idle-high so
// a reset never looks like a start bit.
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw line through the flop chain, oldest sample at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver: 1 start, 7 data bits LSB first, even parity, 1 stop.
// Single mid-bit sample per bit, start-glitch rejection, parity/framing flags.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_rx_sampler_if.master  bus
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] BIT_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    logic                  rx_s;
    state_t                state;
    logic [CW-1:0]         cnt;
    logic [2:0]            bit_idx;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  par;
    logic [DATA_BITS:0]    data_out;
    logic                  out_valid;
    logic                  parity_err;
    logic                  frame_err;
    logic                  busy;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rx),
        .q     (rx_s)
    );

    // Frame FSM: counts to bit mid-points, samples rx_s and registers all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            par        <= 1'b0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_CNT) begin
                        cnt                <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == LAST_IDX) begin
                            state <= PARITY;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PARITY: begin
                    if (cnt == BIT_CNT) begin
                        cnt   <= '0;
                        par   <= rx_s;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    // Leaving at the stop mid-point lets an immediately following
                    // start bit be caught from IDLE.
                    if (cnt == BIT_CNT) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_out   <= {par, shift_reg};
                            out_valid  <= 1'b1;
                            parity_err <= even_parity(shift_reg) ^ par;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    // Hold through a break so a long low line cannot restart a frame.
                    if (rx_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = data_out;
    assign bus.out_valid  = out_valid;
    assign bus.parity_err = parity_err;
    assign bus.frame_err  = frame_err;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: serial frames are driven bit by bit,
// expected characters are queued at drive time and popped on out_valid.
module tb_uart_rx_sampler;
    import uart_pkg::*;

    localparam int unsigned CPB  = 16;
    localparam int unsigned SS   = 2;
    localparam int unsigned HALF = (CPB - 1) / 2;
    localparam int unsigned LAT  = SS + HALF + 9 * CPB + 1;

    typedef struct {
        logic [7:0]  data;
        logic        perr;
        int unsigned at_edge;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc      = 0;
    int unsigned tests    = 0;
    int unsigned failed   = 0;
    int unsigned ov_count = 0;
    int unsigned fe_count = 0;
    int unsigned fe_edge  = 0;
    exp_t        sb[$];

    uart_rx_sampler_if bus();

    uart_rx_sampler #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Posedge counter: after edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_perr(input logic [7:0] c);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(c[i]);
        return (n % 2) != 0;
    endfunction

    // Drive one full frame starting at the current negedge; t0 is the first
    // posedge that samples the start bit.
    task automatic send_frame(input logic [6:0] d, input logic p, input logic stop_bit,
                              input bit push, output int unsigned t0);
        logic [9:0] fr;
        fr = {stop_bit, p, d, 1'b0};
        t0 = cyc + 1;
        if (push) sb.push_back('{data: {p, d}, perr: model_perr({p, d}), at_edge: t0 + LAT});
        for (int i = 0; i < FRAME_BITS; i++) begin
            bus.rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Output monitor: scoreboard pops on out_valid plus per-cycle invariants.
    always @(negedge clk) begin : mon
        exp_t e;
        check("ov_fe_exclusive", 32'(bus.out_valid & bus.frame_err), 32'd0);
        check("perr_qualified", 32'(bus.parity_err & ~bus.out_valid), 32'd0);
        if (bus.frame_err) begin
            fe_count++;
            fe_edge = cyc;
        end
        if (bus.out_valid) begin
            ov_count++;
            check("valid_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("data_out", 32'(bus.data_out), 32'(e.data));
                check("parity_err", 32'(bus.parity_err), 32'(e.perr));
                check("valid_edge", cyc, e.at_edge);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit reached, expected summary before it");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t0;
        int unsigned ov0;
        int unsigned fe0;
        logic [9:0]  fr;

        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data_out", 32'(bus.data_out), 32'h00);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_parity_err", 32'(bus.parity_err), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Good frame 0x55, parity 0
        ov0 = ov_count; fe0 = fe_count;
        send_frame(7'h55, 1'b0, 1'b1, 1'b1, t0);
        repeat (4) @(negedge clk);
        check("good_drained", sb.size(), 32'd0);
        check("good_valid_count", ov_count - ov0, 32'd1);
        check("good_no_frame_err", fe_count - fe0, 32'd0);
        check("good_busy_idle", 32'(bus.busy), 32'd0);

        // Parity error: 0x41 with parity 1
        ov0 = ov_count;
        send_frame(7'h41, 1'b1, 1'b1, 1'b1, t0);
        repeat (4) @(negedge clk);
        check("perr_drained", sb.size(), 32'd0);
        check("perr_valid_count", ov_count - ov0, 32'd1);
        check("perr_data_hold", 32'(bus.data_out), 32'hC1);

        // Framing error: 0x2A, stop low for 40 clocks
        ov0 = ov_count; fe0 = fe_count;
        send_frame(7'h2A, 1'b1, 1'b0, 1'b0, t0);
        repeat (40 - CPB) @(negedge clk);
        check("ferr_busy_low_line", 32'(bus.busy), 32'd1);
        bus.rx = 1'b1;
        @(negedge clk);
        check("ferr_busy_rise1", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("ferr_busy_rise2", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("ferr_busy_rise3", 32'(bus.busy), 32'd0);
        check("ferr_pulse_count", fe_count - fe0, 32'd1);
        check("ferr_pulse_edge", fe_edge, t0 + LAT);
        check("ferr_no_valid", ov_count - ov0, 32'd0);
        check("ferr_data_hold", 32'(bus.data_out), 32'hC1);
        repeat (4) @(negedge clk);

        // Start glitch: 4 clocks low
        ov0 = ov_count; fe0 = fe_count;
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        check("glitch_busy_seen", 32'(bus.busy), 32'd1);
        repeat (20) @(negedge clk);
        check("glitch_busy_idle", 32'(bus.busy), 32'd0);
        check("glitch_no_valid", ov_count - ov0, 32'd0);
        check("glitch_no_frame_err", fe_count - fe0, 32'd0);

        // Reset during DATA bit 3 of 0x7F, then a clean 0x03
        ov0 = ov_count; fe0 = fe_count;
        fr = {1'b1, 1'b1, 7'h7F, 1'b0};
        for (int i = 0; i < 4; i++) begin
            bus.rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = fr[4];
        repeat (CPB / 2) @(negedge clk);
        check("rmid_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_data_out", 32'(bus.data_out), 32'h00);
        check("rmid_out_valid", 32'(bus.out_valid), 32'd0);
        check("rmid_parity_err", 32'(bus.parity_err), 32'd0);
        check("rmid_frame_err", 32'(bus.frame_err), 32'd0);
        check("rmid_busy_cleared", 32'(bus.busy), 32'd0);
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rmid_no_partial", ov_count - ov0, 32'd0);
        send_frame(7'h03, 1'b0, 1'b1, 1'b1, t0);
        repeat (4) @(negedge clk);
        check("rmid_drained", sb.size(), 32'd0);
        check("rmid_valid_count", ov_count - ov0, 32'd1);
        check("rmid_frame_err", fe_count - fe0, 32'd0);
        check("rmid_data", 32'(bus.data_out), 32'h03);

        // Back-to-back frames 0x00, 0x7F, 0x5A with correct parity
        ov0 = ov_count; fe0 = fe_count;
        send_frame(7'h00, model_perr(8'h00), 1'b1, 1'b1, t0);
        send_frame(7'h7F, model_perr(8'h7F), 1'b1, 1'b1, t0);
        send_frame(7'h5A, model_perr(8'h5A), 1'b1, 1'b1, t0);
        repeat (4) @(negedge clk);
        check("b2b_drained", sb.size(), 32'd0);
        check("b2b_valid_count", ov_count - ov0, 32'd3);
        check("b2b_no_frame_err", fe_count - fe0, 32'd0);
        check("b2b_busy_idle", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Stand-alone UART receive end for the link driven by the existing sender: serial 8N1-style frame in, one parallel character out.
- Frame is 1 start bit (low), 7 data bits LSB first, 1 even-parity bit, 1 stop bit (high).
- Adds what the loopback receiver lacks: input synchronisation, mid-bit sampling, glitch rejection on start, and parity and framing error flags.
- Connects to an external rx pin, or to the sender's tx in loopback benches.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); must be >= 4.
- SYNC_STAGES, 2, flops in the rx synchroniser; must be >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  serial line, idle high, asynchronous to clk
- data_out  output  8  [6:0] received data bits, [7] received parity bit
- out_valid  output  1  one-cycle pulse when data_out is valid (stop bit sampled high)
- parity_err  output  1  qualified by out_valid; 1 when even parity of data_out[7:0] fails
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low
- busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - data_out=0, out_valid=0, parity_err=0, frame_err=0, busy=0.
  - State=IDLE, counters=0.
  - Synchroniser flops reset to 1 (line idle).
- Reset mid-frame aborts the frame immediately; no pulse is emitted for a partial frame.
- Synchroniser: rx passes through SYNC_STAGES flops. rx_s is the last stage; the FSM sees only rx_s.
- Let H = (CLKS_PER_BIT-1)/2, using integer division.
- The bit counter is 3 bits. The clk counter is $clog2(CLKS_PER_BIT) bits and resets to 0 on every state change.
- IDLE: when rx_s=0, go to START and clear the clk counter.
- START:
  - Count to H, then sample rx_s.
  - If rx_s=0, go to DATA.
  - If rx_s=1, treat it as a glitch and return to IDLE with no outputs.
- DATA:
  - Every CLKS_PER_BIT clocks, sample rx_s into shift_reg[bit_idx], starting at bit_idx=0 (LSB first).
  - After bit_idx=6 is sampled, go to PARITY.
- PARITY: after CLKS_PER_BIT clocks, sample rx_s as the parity bit, then go to STOP.
- STOP: after CLKS_PER_BIT clocks, sample rx_s.
  - rx_s=1: on the next edge, data_out={par,shift_reg}, out_valid=1 and parity_err=^{par,shift_reg}, all for exactly 1 cycle. Then go to IDLE.
  - rx_s=0: frame_err=1 for 1 cycle; data_out and out_valid stay unchanged. Go to WAIT_IDLE.
- WAIT_IDLE: remain until rx_s=1, then go to IDLE. This handles a break condition without false restarts.
- data_out holds its last valid value until the next good frame; it never changes outside an out_valid cycle.
- Latency: let t0 be the first clk edge that samples rx=0. out_valid rises at edge t0 + SYNC_STAGES + H + 9*CLKS_PER_BIT + 1, exactly. The bench checks that edge.
- Back-to-back frames: a start bit immediately following a stop bit is caught, because STOP returns to IDLE at the stop mid-point.
- Sampling uses one sample at mid-bit; there is no majority vote.
- out_valid and frame_err are never high in the same cycle.
- parity_err is 0 whenever out_valid=0.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE};
  - DATA_BITS=7 and FRAME_BITS=10;
  - an even-parity helper function shared with the sender.
- One natural sub-module: uart_sync, a parameterised SYNC_STAGES flop chain with reset value 1.
- Counters and FSM stay in uart_rx_sampler.

Test Plan (CLKS_PER_BIT=16, H=7, SYNC_STAGES=2):
- Good frame:
  - Stimulus: drive 7-bit 0x55 (four ones) with parity 0.
  - Required: data_out=0x55, out_valid pulses at t0+2+7+144+1 = t0+154, parity_err=0, frame_err never asserts.
- Parity error: drive 0x41 with parity bit 1 → data_out=0xC1, out_valid=1, parity_err=1.
- Framing error:
  - Stimulus: 0x2A with stop=0, held low for 40 clocks, then high.
  - Required: frame_err pulses once, out_valid stays 0, busy stays high until 2 clocks after rx rises, data_out retains its previous value.
- Start glitch: rx low for 4 clocks, then high → busy returns low, no out_valid, no frame_err.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during DATA bit 3 of 0x7F, release, then send 0x03 with parity 0.
  - Required: all outputs go to 0 asynchronously, no pulse for the 0x7F frame, then out_valid with data_out=0x03.
- Loopback: sender feeding uart_rx_sampler with back-to-back 0x00, 0x7F, 0x5A → three out_valid pulses with data_out[6:0] in that order and parity_err=0.
